// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - synchroniser plus counted debouncer with level and edge-pulse outputs
`timescale 1ns/1ps

module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter bit RST_LEVEL       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic DIN,
    output logic DOUT,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_CHANGING = 1'b1;

    // The terminal count is the last qualified mismatch cycle before DOUT flips.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Refuse to elaborate a counter that could never reach its terminal count.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W)) begin : g_bad_param
        $fatal(1, "sync_debounce: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [0:0]             state;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign DOUT = dout_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign BUSY = (state == ST_CHANGING);

    // Metastability chain: DIN ripples one flop per edge, only the last stage is trusted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], DIN};
        end
    end

    // Debounce FSM: count EN-qualified mismatch cycles, flip DOUT and pulse once at the terminal count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            state  <= ST_STABLE;
            dout_q <= RST_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s != dout_q) begin
                // Without an EN tick both STABLE (cnt already 0) and CHANGING simply hold.
                if (EN) begin
                    if (cnt == CNT_LAST) begin
                        dout_q <= s;
                        cnt    <= '0;
                        state  <= ST_STABLE;
                        rise_q <= s;
                        fall_q <= ~s;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ST_CHANGING;
                    end
                end
            end else begin
                // Input agrees with the output again: abandon any debounce in progress.
                cnt   <= '0;
                state <= ST_STABLE;
            end
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - scoreboard bench for sync_debounce
`timescale 1ns/1ps

module tb_sync_debounce;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic EN  = 1'b1;
    logic DIN = 1'b0;
    logic dout, rise, fall, busy;
    logic dout1, rise1, fall1, busy1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int edge_n;
        bit is_rise;
    } ev_t;
    ev_t exp_q[$];

    sync_debounce dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN),
        .DOUT(dout), .RISE(rise), .FALL(fall), .BUSY(busy)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN),
        .DOUT(dout1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every pulse from the default instance must match the oldest expected event.
    initial begin
        ev_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (rise || fall) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_unexpected edge=%0d rise=%0b fall=%0b required no pulse", cyc, rise, fall);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.edge_n || rise !== e.is_rise || fall !== !e.is_rise) begin
                        n_err++;
                        $display("FAIL pulse_event edge=%0d rise=%0b fall=%0b required edge=%0d rise=%0b fall=%0b",
                                 cyc, rise, fall, e.edge_n, e.is_rise, !e.is_rise);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if ({dout, rise, fall, busy} !== 4'b0000 || dut.cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state dout/rise/fall/busy=%b cnt=%0d required 0000 cnt=0",
                     {dout, rise, fall, busy}, dut.cnt);
        end
        RST = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset got=%b required 0000", {dout, rise, fall, busy});
        end
    endtask

    task automatic test_clean_rise();
        int base;
        base = cyc;
        DIN = 1'b1;
        exp_q.push_back('{base + 6, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (busy !== (k >= 3 && k <= 5) || dout !== (k >= 6)) begin
                n_err++;
                $display("FAIL rise_k%0d busy=%0b dout=%0b required busy=%0b dout=%0b",
                         k, busy, dout, (k >= 3 && k <= 5), (k >= 6));
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rise_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_fall();
        int base;
        base = cyc;
        DIN = 1'b0;
        exp_q.push_back('{base + 6, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (dout !== (k < 6) || rise !== 1'b0) begin
                n_err++;
                $display("FAIL fall_k%0d dout=%0b rise=%0b required dout=%0b rise=0", k, dout, rise, (k < 6));
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fall_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int base;
        base = cyc;
        DIN = 1'b1;
        tick();
        tick();
        DIN = 1'b0;
        tick();
        DIN = 1'b1;
        exp_q.push_back('{base + 9, 1'b1});
        for (int k = 4; k <= 12; k++) begin
            tick();
            n_cmp++;
            if (dout !== (k >= 9)) begin
                n_err++;
                $display("FAIL bounce_dout_k%0d got=%0b required=%0b", k, dout, (k >= 9));
            end
            if (k == 5) begin
                n_cmp++;
                if (dut.cnt !== 8'd0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL bounce_restart cnt=%0d busy=%0b required cnt=0 busy=0", dut.cnt, busy);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bounce_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        base = cyc;
        DIN = 1'b0;
        exp_q.push_back('{base + 6, 1'b0});
        repeat (8) tick();
    endtask

    task automatic test_en_gating();
        int base;
        int exp_cnt;
        base = cyc;
        DIN = 1'b1;
        exp_q.push_back('{base + 12, 1'b1});
        for (int k = 1; k <= 14; k++) begin
            EN = (k % 3 == 0);
            tick();
            exp_cnt = (k < 3 || k >= 12) ? 0 : k / 3;
            n_cmp++;
            if (dout !== (k >= 12) || dut.cnt !== exp_cnt[7:0]) begin
                n_err++;
                $display("FAIL en_gate_k%0d dout=%0b cnt=%0d required dout=%0b cnt=%0d",
                         k, dout, dut.cnt, (k >= 12), exp_cnt);
            end
        end
        EN = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL en_gate_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mid_reset();
        int base;
        DIN = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++;
        if (dut.cnt !== 8'd2 || dout !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset cnt=%0d dout=%0b busy=%0b required cnt=2 dout=1 busy=1", dut.cnt, dout, busy);
        end
        #2;
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({dout, rise, fall, busy} !== 4'b0000 || dut.cnt !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset dout/rise/fall/busy=%b cnt=%0d required 0000 cnt=0",
                     {dout, rise, fall, busy}, dut.cnt);
        end
        DIN = 1'b1;
        repeat (2) tick();
        RST = 1'b1;
        base = cyc;
        exp_q.push_back('{base + 6, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (dout !== (k >= 6)) begin
                n_err++;
                $display("FAIL post_reset_k%0d dout=%0b required=%0b", k, dout, (k >= 6));
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL post_reset_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch();
        int base;
        base = cyc;
        DIN = 1'b0;
        exp_q.push_back('{base + 6, 1'b0});
        repeat (8) tick();
        DIN = 1'b1;
        tick();
        DIN = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (dout1 !== (k == 3) || rise1 !== (k == 3) || fall1 !== (k == 4) || busy1 !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_dc1_k%0d dout=%0b rise=%0b fall=%0b busy=%0b required %0b %0b %0b 0",
                         k, dout1, rise1, fall1, busy1, (k == 3), (k == 3), (k == 4));
            end
            n_cmp++;
            if (dout !== 1'b0 || busy !== (k == 3)) begin
                n_err++;
                $display("FAIL glitch_dc4_k%0d dout=%0b busy=%0b required dout=0 busy=%0b", k, dout, busy, (k == 3));
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_missing pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_fall();
        test_bounce();
        test_en_gating();
        test_mid_reset();
        test_glitch();
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Input conditioner that sits directly upstream of the team's registered gating stage (Q <= ~A & B, async reset/preset).
- Takes one raw asynchronous, possibly bouncing signal (button, external strobe) and synchronises it into CLK.
- Debounces it with a qualified-cycle counter and drives a clean level plus single-cycle RISE/FALL pulses.
- One instance is used per A/B input of the downstream stage.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal values are 2 or more.
- DEBOUNCE_CYCLES, 4, consecutive EN-qualified mismatch cycles required before DOUT changes; legal range is 1 to 2^CNT_W.
- CNT_W, 8, debounce counter width.
- RST_LEVEL, 0, value loaded into the synchroniser flops and DOUT during reset.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- EN  input  1  count-enable tick; the counter advances only when EN=1
- DIN  input  1  raw asynchronous input
- DOUT  output  1  debounced, synchronised level
- RISE  output  1  one-cycle pulse, asserted in the same cycle DOUT goes 0->1
- FALL  output  1  one-cycle pulse, asserted in the same cycle DOUT goes 1->0
- BUSY  output  1  1 while state is CHANGING

Behaviour:
- Reset (RST=0, asynchronous, at any time):
  - all synchroniser flops = RST_LEVEL
  - DOUT = RST_LEVEL
  - cnt = 0, state = STABLE
  - RISE = FALL = BUSY = 0
  - a reset in the middle of a debounce aborts it and emits no pulse.
- Synchroniser:
  - DIN shifts through SYNC_STAGES flops every edge.
  - s = last stage. Only s is used by the logic.
- FSM, evaluated every rising edge:
  - STABLE, s==DOUT: stay; cnt=0.
  - STABLE, s!=DOUT, EN=0: stay; cnt holds at 0.
  - STABLE or CHANGING, s!=DOUT, EN=1, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1; next state = CHANGING.
  - STABLE or CHANGING, s!=DOUT, EN=1, cnt == DEBOUNCE_CYCLES-1: DOUT <= s; cnt <= 0; next state = STABLE; RISE or FALL = 1 for this one cycle, matching the direction.
  - CHANGING, s!=DOUT, EN=0: hold cnt and state.
  - CHANGING, s==DOUT (bounce back): cnt <= 0; next state = STABLE; DOUT unchanged; no pulse.
- DEBOUNCE_CYCLES=1: DOUT follows s on the first EN-qualified mismatch edge.
- Latency with EN tied high:
  - DIN changes between edge 0 and edge 1 and then stays stable.
  - DOUT, and its pulse, update at edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 with the defaults).
- Pulses:
  - RISE and FALL are registered and mutually exclusive.
  - Each is high for exactly one cycle per DOUT transition. There is no back-to-back repeat, because the counter restarts from 0.
- Counter:
  - unsigned, CNT_W bits, never wraps; its maximum reached value is DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES > 2^CNT_W is illegal; simulation raises a fatal error at time 0.
- Reset release with DIN != RST_LEVEL:
  - the input is treated as a normal change.
  - the full debounce runs, then DOUT transitions and the matching pulse fires.
- DOUT never changes except through the transition above or through reset.

Test Plan:
1. Clean rise, defaults, EN=1: DIN 0->1 just after edge 0 -> DOUT=1 and RISE=1 at edge 6 only; BUSY=1 from edge 3 through edge 5, 0 at edge 6.
2. Bounce: DIN high for 2 cycles, low for 1, then high and held -> no DOUT change during the bounce; cnt returns to 0; DOUT rises 6 edges after the final DIN rise; exactly one RISE.
3. EN gating: DEBOUNCE_CYCLES=4, EN=1 only every 3rd cycle, DIN held 1 -> DOUT rises on the 4th EN-qualified mismatch edge; cnt holds between ticks.
4. Fall path: DOUT=1 steady, DIN 1->0 held -> DOUT=0 and FALL=1 for one cycle at edge 6; RISE stays 0.
5. Mid-operation reset: RST asserted while cnt=2 -> DOUT, cnt, RISE, FALL, BUSY all 0 immediately (asynchronously); after release with DIN=1 -> full 6-edge debounce, then RISE.
6. Short glitch: a 1-cycle DIN pulse shorter than DEBOUNCE_CYCLES, with DEBOUNCE_CYCLES=1 versus 4 -> with 1, DOUT follows after 3 edges; with 4, DOUT never changes.
